// File: rtl/led_pkg.sv
// Shared constants for the LED chaser / trail family.
package led_pkg;

    localparam int LED_COUNT         = 8;
    localparam int PWM_BITS_DEFAULT  = 4;
    localparam int LEVEL_MAX_DEFAULT = (1 << PWM_BITS_DEFAULT) - 1;

endpackage

// File: rtl/led_trail_channel.sv
// One LED: brightness level with set/decay, PWM compare and registered drive.
module led_trail_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEFAULT,
    parameter int DECAY_STEP = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pattern_bit,
    input  logic                decay_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led
);

    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
    localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(DECAY_STEP);

    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] level_next;

    // A lit pattern bit always wins over decay; decay saturates at zero.
    always_comb begin
        level_next = level;
        if (pattern_bit) begin
            level_next = LEVEL_MAX;
        end else if (decay_tick) begin
            level_next = (level > STEP) ? level - STEP : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            led   <= 1'b0;
        end else begin
            level <= level_next;
            led   <= (pwm_cnt < level);
        end
    end

endmodule

// File: rtl/led_trail_pwm.sv
// Fading trail behind an 8-LED chaser: shared decay prescaler and PWM counter.
module led_trail_pwm
    import led_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEFAULT,
    parameter int DECAY_DIV  = 16,
    parameter int DECAY_STEP = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [LED_COUNT-1:0] led_pattern,
    output logic [LED_COUNT-1:0] led_out,
    output logic                 frame_start
);

    localparam int DIV_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DIV_W-1:0]    PRESC_LAST = DIV_W'(DECAY_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST   = PWM_BITS'((1 << PWM_BITS) - 2);

    logic [DIV_W-1:0]    presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                decay_tick;

    assign decay_tick = enable && (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (enable) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end
    end

    // Period is LEVEL_MAX cycles so that a full level gives 100% duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt     <= '0;
            frame_start <= 1'b0;
        end else begin
            pwm_cnt     <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
            frame_start <= (pwm_cnt == '0);
        end
    end

    for (genvar i = 0; i < LED_COUNT; i++) begin : g_ch
        led_trail_channel #(
            .PWM_BITS   (PWM_BITS),
            .DECAY_STEP (DECAY_STEP)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .pattern_bit (led_pattern[i]),
            .decay_tick  (decay_tick),
            .pwm_cnt     (pwm_cnt),
            .led         (led_out[i])
        );
    end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Self-checking bench for led_trail_pwm: cycle scoreboard plus directed duty checks.
module tb_led_trail_pwm;

    localparam int DIV  = 16;
    localparam int STEP = 4;
    localparam int LMAX = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] led_pattern = 8'hFF;
    logic [7:0] led_out;
    logic       frame_start;

    int total = 0;
    int bad   = 0;

    logic [8:0] sb[$];
    int m_lvl[8];
    int m_presc = 0;
    int m_pwm   = 0;
    int now_cyc = 0;
    int last_fs = -1;

    always #5 clk = ~clk;

    led_trail_pwm #(
        .PWM_BITS   (4),
        .DECAY_DIV  (DIV),
        .DECAY_STEP (STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .led_pattern (led_pattern),
        .led_out     (led_out),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Predict the outputs registered at the coming edge, then advance the model.
    task automatic model_cycle();
        logic [8:0] e;
        bit tick;
        e = '0;
        if (!rst) begin
            for (int i = 0; i < 8; i++) e[i] = (m_pwm < m_lvl[i]);
            e[8] = (m_pwm == 0);
        end
        sb.push_back(e);
        if (rst) begin
            for (int i = 0; i < 8; i++) m_lvl[i] = 0;
            m_presc = 0;
            m_pwm   = 0;
        end else begin
            tick = enable && (m_presc == DIV - 1);
            for (int i = 0; i < 8; i++) begin
                if (led_pattern[i]) begin
                    m_lvl[i] = LMAX;
                end else if (tick) begin
                    m_lvl[i] = m_lvl[i] - STEP;
                    if (m_lvl[i] < 0) m_lvl[i] = 0;
                end
            end
            if (enable) m_presc = (m_presc + 1) % DIV;
            m_pwm = (m_pwm + 1) % LMAX;
        end
    endtask

    task automatic step();
        logic [8:0] e;
        logic       was_rst;
        was_rst = rst;
        model_cycle();
        @(posedge clk);
        #1;
        now_cyc++;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("led_out", int'(led_out), int'(e[7:0]));
            check("frame_start", int'(frame_start), int'(e[8]));
        end
        if (was_rst) begin
            last_fs = -1;
        end else if (frame_start) begin
            if (last_fs >= 0) check("fs_gap", now_cyc - last_fs, 15);
            last_fs = now_cyc;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic measure(output int cnt);
        cnt = 0;
        repeat (15) begin
            step();
            cnt += int'(led_out[0]);
        end
    endtask

    // Reset with a full pattern applied to also exercise reset priority.
    task automatic do_reset(input int n);
        rst = 1'b1;
        led_pattern = 8'hFF;
        enable = 1'b1;
        repeat (n) begin
            step();
            check("rst_led", int'(led_out), 0);
            check("rst_fs", int'(frame_start), 0);
        end
        rst = 1'b0;
        led_pattern = 8'h00;
    endtask

    // First cycle after release: pulse bit 0 once; frame_start must follow.
    task automatic pulse_after_reset();
        led_pattern = 8'h01;
        step();
        check("fs_after_rst", int'(frame_start), 1);
        led_pattern = 8'h00;
    endtask

    initial begin
        int d;
        #1;
        do_reset(3);

        // Held pattern: bit 0 fully on two cycles after first sample.
        led_pattern = 8'h01;
        step();
        check("hold_first", int'(led_out), 0);
        repeat (40) begin
            step();
            check("hold", int'(led_out), 8'h01);
        end

        // Decay staircase 15,11,7,3,0 measured per 15-cycle window.
        do_reset(1);
        pulse_after_reset();
        measure(d); check("duty_l15", d, 15);
        measure(d); check("duty_l11", d, 11);
        run(1); measure(d); check("duty_l7", d, 7);
        run(1); measure(d); check("duty_l3", d, 3);
        run(1); measure(d); check("duty_l0", d, 0);

        // Freeze at level 11, then re-light during the freeze.
        do_reset(1);
        pulse_after_reset();
        run(16);
        enable = 1'b0;
        run(12);
        measure(d); check("freeze_l11a", d, 11);
        run(34);
        measure(d); check("freeze_l11b", d, 11);
        led_pattern = 8'h01;
        step();
        led_pattern = 8'h00;
        measure(d); check("freeze_set15", d, 15);
        enable = 1'b1;

        // Pattern on the decay-tick cycle while level is 7 restores 15.
        do_reset(1);
        pulse_after_reset();
        run(46);
        led_pattern = 8'h01;
        step();
        led_pattern = 8'h00;
        measure(d); check("tick_set15", d, 15);

        // Mid-trail reset leaves no residual glow.
        led_pattern = 8'hA5;
        run(3);
        led_pattern = 8'h00;
        run(20);
        do_reset(1);
        step();
        check("fs_after_rst2", int'(frame_start), 1);
        repeat (15) begin
            step();
            check("no_glow", int'(led_out), 0);
        end

        // Random patterns, enable toggling and occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            enable = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0: led_pattern = 8'h00;
                1: led_pattern = 8'hFF;
                2: led_pattern = 8'h01 << $urandom_range(0, 7);
                default: led_pattern = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            endcase
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
